// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of an asynchronous PWM line
module pwm_capture #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_cycle,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             level
);
  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  state_t           r_state;
  logic             r_s1, r_s2, r_prev;
  logic [WIDTH-1:0] r_high_cnt, r_per_cnt;
  logic             w_rise, w_fall, w_stuck;
  assign level   = r_s2;
  assign w_rise  = r_s2 & ~r_prev;
  assign w_fall  = ~r_s2 & r_prev;
  assign w_stuck = (r_state != WAIT_RISE) && (r_per_cnt == MAX) && !w_rise && !w_fall;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= WAIT_RISE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_prev     <= 1'b0;
      r_high_cnt <= '0;
      r_per_cnt  <= '0;
      duty_cycle <= '0;
      period     <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      r_s1   <= pwm_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      valid  <= 1'b0;
      if (clear) begin
        r_state    <= WAIT_RISE;
        r_high_cnt <= '0;
        r_per_cnt  <= '0;
        timeout    <= 1'b0;
      end else if (w_stuck) begin
        r_state    <= WAIT_RISE;
        r_high_cnt <= '0;
        r_per_cnt  <= '0;
        timeout    <= 1'b1;
      end else begin
        case (r_state)
          WAIT_RISE: begin
            r_state    <= w_rise ? MEAS_HIGH : WAIT_RISE;
            r_high_cnt <= w_rise ? ONE : '0;
            r_per_cnt  <= w_rise ? ONE : '0;
          end
          MEAS_HIGH: begin
            r_state    <= w_fall ? MEAS_LOW : MEAS_HIGH;
            r_high_cnt <= w_fall ? r_high_cnt : r_high_cnt + 1'b1;
            r_per_cnt  <= r_per_cnt + 1'b1;
          end
          MEAS_LOW: begin
            r_state    <= w_rise ? MEAS_HIGH : MEAS_LOW;
            r_high_cnt <= w_rise ? ONE : r_high_cnt;
            r_per_cnt  <= w_rise ? ONE : r_per_cnt + 1'b1;
            duty_cycle <= w_rise ? r_high_cnt : duty_cycle;
            period     <= w_rise ? r_per_cnt : period;
            valid      <= w_rise;
            timeout    <= w_rise ? 1'b0 : timeout;
          end
          default: r_state <= WAIT_RISE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized PWM stimulus checked every cycle against a timestamp-based model
module tb_pwm_capture;
  localparam int W = 13;
  localparam int MAX = (1 << W) - 1;
  logic clk = 1'b0, rst, clear, pwm_in;
  logic [W-1:0] duty_cycle, period;
  logic valid, timeout, level;
  int n_checks = 0, n_fail = 0, n_valid = 0;
  pwm_capture #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .pwm_in(pwm_in),
    .duty_cycle(duty_cycle), .period(period), .valid(valid),
    .timeout(timeout), .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  bit hist [4] = '{0, 0, 0, 0};
  int e = 0, t0 = 0, tf = 0;
  bit armed = 0, seen_fall = 0, rise, fall;
  int m_duty = 0, m_period = 0;
  bit m_valid = 0, m_timeout = 0, m_level = 0;
  always @(posedge clk) begin
    e++;
    hist[e % 4] = pwm_in;
    m_valid = 0;
    if (rst) begin
      hist[e % 4] = 0;
      hist[(e + 3) % 4] = 0;
      hist[(e + 2) % 4] = 0;
      armed = 0;
      seen_fall = 0;
      m_duty = 0;
      m_period = 0;
      m_timeout = 0;
    end else begin
      rise = hist[(e + 2) % 4] && !hist[(e + 1) % 4];
      fall = !hist[(e + 2) % 4] && hist[(e + 1) % 4];
      if (clear) begin
        armed = 0;
        m_timeout = 0;
      end else if (armed && !rise && !fall && e - t0 == MAX) begin
        armed = 0;
        m_timeout = 1;
      end else if (rise) begin
        if (armed && seen_fall) begin
          m_duty = tf - t0;
          m_period = e - t0;
          m_valid = 1;
          m_timeout = 0;
        end
        armed = 1;
        seen_fall = 0;
        t0 = e;
      end else if (fall && armed) begin
        seen_fall = 1;
        tf = e;
      end
    end
    m_level = hist[(e + 3) % 4];
  end
  bit last_v = 0;
  always @(negedge clk) begin
    chk("duty_cycle", duty_cycle, m_duty);
    chk("period", period, m_period);
    chk("valid", valid, m_valid);
    chk("timeout", timeout, m_timeout);
    chk("level", level, m_level);
    chk("valid_back_to_back", valid && last_v, 0);
    last_v = valid;
    if (valid) n_valid++;
  end
  task automatic cyc(bit v, int n);
    repeat (n) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask
  task automatic pulse(int h, int p);
    cyc(1, h);
    cyc(0, p - h);
  endtask
  int v0, p, h;
  initial begin
    rst = 1;
    clear = 0;
    pwm_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_level", level, 0);
    rst = 0;
    cyc(0, MAX + 10);
    chk("idle_low_no_timeout", timeout, 0);
    v0 = n_valid;
    repeat (3) pulse(1024, 4096);
    chk("p1024_valid_count", n_valid - v0, 2);
    chk("p1024_duty", duty_cycle, 1024);
    chk("p1024_period", period, 4096);
    repeat (3) pulse(1, 4096);
    chk("gen1_duty", duty_cycle, 1);
    chk("gen1_period", period, 4096);
    repeat (3) pulse(4095, 4096);
    chk("gen4095_duty", duty_cycle, 4095);
    chk("gen4095_period", period, 4096);
    v0 = n_valid;
    cyc(0, MAX + 10);
    chk("gen0_no_valid", n_valid - v0, 0);
    chk("gen0_timeout", timeout, 1);
    repeat (10) pulse(1, 2);
    chk("min_duty", duty_cycle, 1);
    chk("min_period", period, 2);
    repeat (5) pulse(10, 30);
    cyc(1, 10);
    cyc(0, MAX - 7);
    chk("timeout_not_yet", timeout, 0);
    cyc(0, 1);
    chk("timeout_exact", timeout, 1);
    chk("timeout_duty_hold", duty_cycle, 10);
    chk("timeout_period_hold", period, 30);
    cyc(1, 5);
    chk("timeout_survives_rise", timeout, 1);
    cyc(1, 5);
    cyc(0, 20);
    cyc(1, 5);
    chk("timeout_cleared_by_valid", timeout, 0);
    chk("resume_duty", duty_cycle, 10);
    chk("resume_period", period, 30);
    cyc(1, 5);
    cyc(0, 20);
    repeat (3) pulse(10, 30);
    cyc(1, 5);
    clear = 1;
    v0 = n_valid;
    cyc(1, 1);
    clear = 0;
    cyc(1, 5);
    cyc(0, 20);
    repeat (3) pulse(12, 40);
    chk("clear_valid_count", n_valid - v0, 2);
    chk("clear_next_duty", duty_cycle, 12);
    chk("clear_next_period", period, 40);
    cyc(1, 5);
    rst = 1;
    cyc(1, 1);
    chk("midrst_duty", duty_cycle, 0);
    chk("midrst_period", period, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_level", level, 0);
    rst = 0;
    cyc(1, 5);
    cyc(0, 20);
    repeat (3) pulse(7, 19);
    chk("rst_next_duty", duty_cycle, 7);
    chk("rst_next_period", period, 19);
    cyc(0, 10);
    cyc(1, 3);
    clear = 1;
    cyc(1, 1);
    clear = 0;
    v0 = n_valid;
    cyc(1, 7);
    cyc(0, 20);
    cyc(1, 5);
    chk("clear_on_rise_ignored", n_valid - v0, 0);
    cyc(0, 20);
    for (int i = 0; i < 200; i++) begin
      p = $urandom_range(120, 2);
      h = $urandom_range(p - 1, 1);
      pulse(h, p);
    end
    cyc(1, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
